sd_rx_burst_filler: RTL

SD_RX_BURST_FILLER -- requirements
Module: sd_rx_burst_filler

---
 rtl/sd_rx_pkg.sv | 15 +
 rtl/sd_rx_sync_fifo.sv | 60 ++++++
 rtl/sd_rx_burst_filler.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sd_rx_pkg.sv
// Shared FSM state type and Wishbone cycle-type constants for the SD receive burst filler.
package sd_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/sd_rx_sync_fifo.sv
// Single-clock word FIFO with show-ahead head (dout valid whenever level != 0) and a flush input.
module sd_rx_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_level == LVL_FULL);
    assign empty     = (r_level == '0);
    assign w_push_ok = push & ~full & ~flush;
    assign w_pop_ok  = pop & ~empty & ~flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= din;
    end

    // Asynchronous read: the bus master presents the head word in the same cycle stb rises.
    assign dout  = r_mem[r_rd_ptr];
    assign level = r_level;

endmodule

// File: rtl/sd_rx_burst_filler.sv
// Packs SD receive data into 32-bit words and writes them out as Wishbone bursts.
// Define SD_RX_BURST_EN for BURST_LEN-beat incrementing bursts; otherwise single-beat classic cycles.
module sd_rx_burst_filler
    import sd_rx_pkg::*;
#(
    parameter int IN_W      = 4,
    parameter int DEPTH     = 16,
    parameter int BURST_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [31:0]              adr,
    input  logic [IN_W-1:0]          dat_i,
    input  logic                     wr,
    output logic [31:0]              m_wb_adr_o,
    output logic                     m_wb_we_o,
    output logic [31:0]              m_wb_dat_o,
    output logic                     m_wb_cyc_o,
    output logic                     m_wb_stb_o,
    output logic [2:0]               m_wb_cti_o,
    output logic [1:0]               m_wb_bte_o,
    input  logic                     m_wb_ack_i,
    input  logic                     m_wb_err_i,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     bus_err
);

    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int BEATS = 32 / IN_W;
    localparam int CW    = $clog2(BEATS);

    if (!(IN_W == 4 || IN_W == 8) || DEPTH < 4 || BURST_LEN > DEPTH) begin : g_bad_cfg
        $error("sd_rx_burst_filler: illegal IN_W/DEPTH/BURST_LEN combination");
    end

    state_t          r_state;
    state_t          w_state_next;
    logic            r_en_d;
    logic            w_en_rise;
    logic [31:0]     r_shift;
    logic [CW-1:0]   r_nib;
    logic [31:0]     w_shift_next;
    logic            w_word_done;
    logic [31:0]     r_adr;
    logic            r_overflow;
    logic            r_bus_err;
    logic [31:0]     w_fifo_dout;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [LW-1:0]   w_level;
    logic            w_flush;
    logic            w_in_burst;
    logic            w_pop;
    logic            w_start;
    logic            w_last_beat;
    logic [2:0]      w_cti;

    assign w_en_rise    = en & ~r_en_d;
    assign w_flush      = ~en;
    assign w_in_burst   = (r_state == BURST);
    assign w_pop        = w_in_burst & en & m_wb_ack_i & ~m_wb_err_i;
    assign w_shift_next = {r_shift[31-IN_W:0], dat_i};
    assign w_word_done  = en & wr & (r_nib == CW'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst)
            r_en_d <= 1'b0;
        else
            r_en_d <= en;
    end

    // MSB-first packer: the first symbol of a word ends up in bits [31 -: IN_W].
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_shift <= '0;
            r_nib   <= '0;
        end else if (wr) begin
            r_shift <= w_shift_next;
            r_nib   <= r_nib + CW'(1);
        end
    end

    sd_rx_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (w_flush),
        .push  (w_word_done),
        .pop   (w_pop),
        .din   (w_shift_next),
        .dout  (w_fifo_dout),
        .level (w_level),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

`ifdef SD_RX_BURST_EN
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    logic [BW-1:0] r_beat;

    always_ff @(posedge clk) begin
        if (rst || !w_in_burst)
            r_beat <= '0;
        else if (w_pop)
            r_beat <= r_beat + BW'(1);
    end

    assign w_last_beat = (r_beat == BW'(BURST_LEN - 1));
    assign w_start     = (w_level >= LW'(BURST_LEN));
    assign w_cti       = w_in_burst ? (w_last_beat ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;
`else
    assign w_last_beat = 1'b1;
    assign w_start     = ~w_fifo_empty;
    assign w_cti       = CTI_CLASSIC;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // A latched bus error blocks new bursts until en drops, which also clears it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (!r_bus_err && w_start) w_state_next = BURST;
            BURST:   if (m_wb_err_i || (w_pop && w_last_beat)) w_state_next = GAP;
            GAP:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (!en)
            w_state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_adr <= '0;
        else if (w_en_rise)
            r_adr <= adr;
        else if (w_pop)
            r_adr <= r_adr + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_overflow <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            if (w_word_done && w_fifo_full)
                r_overflow <= 1'b1;
            if (w_in_burst && m_wb_err_i)
                r_bus_err <= 1'b1;
        end
    end

    assign m_wb_cyc_o = w_in_burst;
    assign m_wb_stb_o = w_in_burst;
    assign m_wb_we_o  = w_in_burst;
    assign m_wb_dat_o = w_in_burst ? w_fifo_dout : 32'd0;
    assign m_wb_adr_o = r_adr;
    assign m_wb_cti_o = w_cti;
    assign m_wb_bte_o = BTE_LINEAR;

    assign full     = w_fifo_full;
    assign empty    = w_fifo_empty;
    assign level    = w_level;
    assign overflow = r_overflow;
    assign bus_err  = r_bus_err;

endmodule
